// File: rtl/outbox_tx_streamer_pkg.sv
// Shared constants and state encoding for the outbox-to-UART streamer.
// Reused by the top module and its bench so the encodings live in one place.
package outbox_tx_streamer_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Enough for 8 hex digits plus a two-character CR LF terminator.
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/outbox_tx_streamer_nib2ascii.sv
// Combinational nibble to uppercase hex ASCII character.
module outbox_tx_streamer_nib2ascii (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    if (nib < 4'd10) chr = 8'h30 + {4'h0, nib};
    else             chr = 8'h41 + ({4'h0, nib} - 8'd10);
  end

endmodule

// File: rtl/outbox_tx_streamer.sv
// Drains a FWFT outbox into a UART transmitter, one word at a time, as raw bytes or hex text.
//
//   state | meaning
//   IDLE  | nothing in flight; pop the outbox head when enabled and non-empty
//   EMIT  | present the current character once the UART is not busy
//   GAP   | one-cycle holdoff so the UART busy flag is visible; advance or finish
module outbox_tx_streamer
  import outbox_tx_streamer_pkg::*;
#(
  parameter int         DATA_W         = 8,
  parameter int         HEX_MODE       = 0,
  parameter logic [7:0] SEP_CHAR       = 8'h20,
  parameter int         WORDS_PER_LINE = 0,
  parameter int         CNT_W          = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_empty_n,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_pop,
  input  logic              i_tx_busy,
  output logic              o_tx_wr,
  output logic [7:0]        o_tx_data,
  output logic              o_idle,
  output logic [CNT_W-1:0]  o_word_cnt
);

  localparam int NNIB   = DATA_W / 4;
  localparam int NBYTES = DATA_W / 8;
  localparam int LINE_W = (WORDS_PER_LINE > 0) ? $clog2(WORDS_PER_LINE + 1) : 1;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, last_idx;
  logic [LINE_W-1:0]  line_cnt, line_nxt, line_inc;
  logic               crlf, crlf_nxt;
  logic               pop_nxt, wr_nxt, idle_nxt;
  logic [7:0]         txd_nxt, nib_chr, cur_char;
  logic [CNT_W-1:0]   cnt_nxt;

  outbox_tx_streamer_nib2ascii u_nib2ascii (
    .nib (shreg[DATA_W-1 -: 4]),
    .chr (nib_chr)
  );

  assign line_inc = line_cnt + LINE_W'(1);

  // Index of the final character of the current word, terminator included.
  always_comb begin
    if (HEX_MODE != 0) last_idx = IDX_W'(NNIB) + {{(IDX_W-1){1'b0}}, crlf};
    else               last_idx = IDX_W'(NBYTES - 1);
  end

  always_comb begin
    cur_char = shreg[DATA_W-1 -: 8];
    if (HEX_MODE != 0) begin
      if (idx < IDX_W'(NNIB))       cur_char = nib_chr;
      else if (!crlf)               cur_char = SEP_CHAR;
      else if (idx == IDX_W'(NNIB)) cur_char = ASCII_CR;
      else                          cur_char = ASCII_LF;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    line_nxt  = line_cnt;
    crlf_nxt  = crlf;
    pop_nxt   = 1'b0;
    wr_nxt    = 1'b0;
    txd_nxt   = o_tx_data;
    cnt_nxt   = o_word_cnt;
    case (state)
      ST_IDLE: begin
        if (i_enable && i_empty_n) begin
          pop_nxt   = 1'b1;
          shreg_nxt = i_data;
          idx_nxt   = '0;
          crlf_nxt  = 1'b0;
          state_nxt = ST_EMIT;
          // The line break decision is fixed when the word is taken.
          if (HEX_MODE != 0 && WORDS_PER_LINE != 0) begin
            if (line_inc == LINE_W'(WORDS_PER_LINE)) begin
              crlf_nxt = 1'b1;
              line_nxt = '0;
            end else begin
              line_nxt = line_inc;
            end
          end
        end
      end
      ST_EMIT: begin
        if (!i_tx_busy) begin
          wr_nxt    = 1'b1;
          txd_nxt   = cur_char;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (idx == last_idx) begin
          cnt_nxt   = o_word_cnt + CNT_W'(1);
          state_nxt = ST_IDLE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          shreg_nxt = (HEX_MODE != 0) ? (shreg << 4) : (shreg << 8);
          state_nxt = ST_EMIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    idle_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      idx        <= '0;
      line_cnt   <= '0;
      crlf       <= 1'b0;
      o_pop      <= 1'b0;
      o_tx_wr    <= 1'b0;
      o_tx_data  <= 8'h00;
      o_idle     <= 1'b1;
      o_word_cnt <= '0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      idx        <= idx_nxt;
      line_cnt   <= line_nxt;
      crlf       <= crlf_nxt;
      o_pop      <= pop_nxt;
      o_tx_wr    <= wr_nxt;
      o_tx_data  <= txd_nxt;
      o_idle     <= idle_nxt;
      o_word_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_outbox_tx_streamer.sv
// Directed bench: three streamer configurations (raw 8b, hex 16b, hex 8b with line breaks)
// fed by a small outbox model and a UART busy model, all driven from one initial block.
module tb_outbox_tx_streamer;

  localparam int BUSY_LEN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       en, empty_n, busy, pop, wr, idle;
  logic [2:0][7:0]  txd;
  logic [7:0]       d0, d2;
  logic [15:0]      d1;
  logic [1:0]       cnt0;
  logic [15:0]      cnt1;
  logic [7:0]       cnt2;

  logic [15:0] fmem [3][16];
  int          fhead [3];
  int          ftail [3];
  logic [7:0]  tlog [3][32];
  int          tn [3];
  int          npop [3];
  int          bcnt [3];
  logic [2:0]  force_busy;
  logic [2:0]  prev_pop;
  int          pop_empty_err, pop_consec_err, wr_busy_err;
  int          n_assert, n_fail;
  int          base;

  outbox_tx_streamer #(.DATA_W(8), .HEX_MODE(0), .CNT_W(2)) dut_raw (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_empty_n(empty_n[0]), .i_data(d0),
    .o_pop(pop[0]), .i_tx_busy(busy[0]), .o_tx_wr(wr[0]), .o_tx_data(txd[0]),
    .o_idle(idle[0]), .o_word_cnt(cnt0)
  );

  outbox_tx_streamer #(.DATA_W(16), .HEX_MODE(1), .WORDS_PER_LINE(0), .CNT_W(16)) dut_hex16 (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_empty_n(empty_n[1]), .i_data(d1),
    .o_pop(pop[1]), .i_tx_busy(busy[1]), .o_tx_wr(wr[1]), .o_tx_data(txd[1]),
    .o_idle(idle[1]), .o_word_cnt(cnt1)
  );

  outbox_tx_streamer #(.DATA_W(8), .HEX_MODE(1), .WORDS_PER_LINE(2), .CNT_W(8)) dut_hex8 (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en[2]), .i_empty_n(empty_n[2]), .i_data(d2),
    .o_pop(pop[2]), .i_tx_busy(busy[2]), .o_tx_wr(wr[2]), .o_tx_data(txd[2]),
    .o_idle(idle[2]), .o_word_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo(input int i);
    empty_n[i] = (fhead[i] != ftail[i]);
    case (i)
      0:       d0 = fmem[0][fhead[0]][7:0];
      1:       d1 = fmem[1][fhead[1]];
      default: d2 = fmem[2][fhead[2]][7:0];
    endcase
  endtask

  task automatic push(input int i, input logic [15:0] w);
    fmem[i][ftail[i]] = w;
    ftail[i]++;
    drive_fifo(i);
  endtask

  // One clock: observe registered outputs just after the edge, then update models.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (pop[i]) begin
        if (fhead[i] == ftail[i]) pop_empty_err++;
        if (prev_pop[i]) pop_consec_err++;
        fhead[i]++;
        npop[i]++;
      end
      prev_pop[i] = pop[i];
      if (wr[i]) begin
        if (busy[i]) wr_busy_err++;
        if (tn[i] < 32) tlog[i][tn[i]] = txd[i];
        tn[i]++;
      end
      if (bcnt[i] > 0) bcnt[i]--;
      if (wr[i]) bcnt[i] = BUSY_LEN;
      busy[i] = force_busy[i] || (bcnt[i] > 0);
      drive_fifo(i);
    end
  endtask

  task automatic run_until_idle(input int i, input int budget, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(idle[i] && fhead[i] == ftail[i]) && k < budget);
    chk(tag, k < budget, 1'b1);
  endtask

  task automatic wait_tx(input int i, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (tn[i] < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, tn[i] >= target, 1'b1);
  endtask

  task automatic wait_pop(input int i, input int budget, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!pop[i] && k < budget);
    chk(tag, pop[i], 1'b1);
  endtask

  task automatic chk_reset_outputs(input int i, input string tag);
    chk({tag, "_pop"},  pop[i],  1'b0);
    chk({tag, "_wr"},   wr[i],   1'b0);
    chk({tag, "_txd"},  txd[i],  8'h00);
    chk({tag, "_idle"}, idle[i], 1'b1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    pop_empty_err = 0; pop_consec_err = 0; wr_busy_err = 0;
    en = '0; busy = '0; empty_n = '0; force_busy = '0; prev_pop = '0;
    d0 = '0; d1 = '0; d2 = '0;
    for (int i = 0; i < 3; i++) begin
      fhead[i] = 0; ftail[i] = 0; tn[i] = 0; npop[i] = 0; bcnt[i] = 0;
      for (int j = 0; j < 16; j++) fmem[i][j] = '0;
      for (int j = 0; j < 32; j++) tlog[i][j] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) chk_reset_outputs(i, "rst");
    chk("rst_cnt0", cnt0, 2'd0);
    chk("rst_cnt1", cnt1, 16'd0);
    chk("rst_cnt2", cnt2, 8'd0);
    rst_n = 1'b1;
    step();

    // Raw bytes, two words with a 5-cycle busy UART.
    push(0, 16'h0041);
    push(0, 16'h0042);
    en[0] = 1'b1;
    run_until_idle(0, 200, "t1_done");
    chk("t1_ntx",  tn[0], 2);
    chk("t1_b0",   tlog[0][0], 8'h41);
    chk("t1_b1",   tlog[0][1], 8'h42);
    chk("t1_npop", npop[0], 2);
    chk("t1_cnt",  cnt0, 2'd2);
    chk("t1_idle", idle[0], 1'b1);
    en[0] = 1'b0;

    // Hex 16-bit word, space separator.
    push(1, 16'h1A2F);
    en[1] = 1'b1;
    run_until_idle(1, 200, "t2_done");
    chk("t2_ntx",  tn[1], 5);
    chk("t2_c0",   tlog[1][0], 8'h31);
    chk("t2_c1",   tlog[1][1], 8'h41);
    chk("t2_c2",   tlog[1][2], 8'h32);
    chk("t2_c3",   tlog[1][3], 8'h46);
    chk("t2_sep",  tlog[1][4], 8'h20);
    chk("t2_npop", npop[1], 1);
    chk("t2_cnt",  cnt1, 16'd1);

    // Hex 8-bit words, CR LF after every second word.
    push(2, 16'h0000);
    push(2, 16'h00FF);
    en[2] = 1'b1;
    run_until_idle(2, 300, "t3_done");
    chk("t3_ntx", tn[2], 7);
    chk("t3_c0",  tlog[2][0], 8'h30);
    chk("t3_c1",  tlog[2][1], 8'h30);
    chk("t3_sep", tlog[2][2], 8'h20);
    chk("t3_c3",  tlog[2][3], 8'h46);
    chk("t3_c4",  tlog[2][4], 8'h46);
    chk("t3_cr",  tlog[2][5], 8'h0D);
    chk("t3_lf",  tlog[2][6], 8'h0A);
    chk("t3_cnt", cnt2, 8'd2);

    // UART busy held for 50 cycles after the second character of 0xBE5F.
    push(1, 16'hBE5F);
    wait_tx(1, 7, 100, "t4_reach");
    force_busy[1] = 1'b1;
    busy[1] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      chk("t4_wr_held", wr[1], 1'b0);
      chk("t4_txd_hold", txd[1], 8'h45);
    end
    force_busy[1] = 1'b0;
    bcnt[1] = 0;
    busy[1] = 1'b0;
    step();
    chk("t4_resume_wr",  wr[1], 1'b1);
    chk("t4_resume_txd", txd[1], 8'h35);
    run_until_idle(1, 200, "t4_done");
    chk("t4_ntx",  tn[1], 10);
    chk("t4_c0",   tlog[1][5], 8'h42);
    chk("t4_c1",   tlog[1][6], 8'h45);
    chk("t4_c2",   tlog[1][7], 8'h35);
    chk("t4_c3",   tlog[1][8], 8'h46);
    chk("t4_sep",  tlog[1][9], 8'h20);
    chk("t4_cnt",  cnt1, 16'd2);
    chk("t4_npop", npop[1], 2);

    // Enable dropped one cycle after the pop with three words queued.
    push(0, 16'h0011);
    push(0, 16'h0022);
    push(0, 16'h0033);
    step();
    chk("t5_no_pop_disabled", npop[0], 2);
    en[0] = 1'b1;
    wait_pop(0, 20, "t5_pop");
    step();
    en[0] = 1'b0;
    for (int c = 0; c < 40; c++) step();
    chk("t5_npop_hold", npop[0], 3);
    chk("t5_ntx_hold",  tn[0], 3);
    chk("t5_b0",        tlog[0][2], 8'h11);
    chk("t5_idle",      idle[0], 1'b1);
    chk("t5_cnt_mid",   cnt0, 2'd3);
    en[0] = 1'b1;
    run_until_idle(0, 300, "t5_done");
    chk("t5_npop", npop[0], 5);
    chk("t5_ntx",  tn[0], 5);
    chk("t5_b1",   tlog[0][3], 8'h22);
    chk("t5_b2",   tlog[0][4], 8'h33);
    chk("t5_cnt_wrap", cnt0, 2'd1);

    // Asynchronous reset between edges with a hex word partly sent.
    base = tn[2];
    push(2, 16'h00A5);
    wait_tx(2, base + 1, 100, "t6_reach");
    chk("t6_first", tlog[2][base], 8'h41);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(2, "t6_async");
    chk("t6_cnt2", cnt2, 8'd0);
    chk("t6_cnt0", cnt0, 2'd0);
    chk("t6_cnt1", cnt1, 16'd0);
    push(2, 16'h003C);
    step();
    chk("t6_pop_in_rst", pop[2], 1'b0);
    rst_n = 1'b1;
    #1;
    chk("t6_pop_at_release", pop[2], 1'b0);
    base = tn[2];
    step();
    chk("t6_pop_after", pop[2], 1'b1);
    run_until_idle(2, 200, "t6_done");
    chk("t6_ntx", tn[2], base + 3);
    chk("t6_c0",  tlog[2][base],     8'h33);
    chk("t6_c1",  tlog[2][base + 1], 8'h43);
    chk("t6_sep", tlog[2][base + 2], 8'h20);
    chk("t6_cnt", cnt2, 8'd1);

    chk("pop_while_empty", pop_empty_err,  0);
    chk("pop_consecutive", pop_consec_err, 0);
    chk("wr_while_busy",   wr_busy_err,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
